// File: rtl/operand_fetch.sv
// operand_fetch: decode-side front end for the 16x32 register file.
// Define OPERAND_FETCH_BYPASS_EN for forwarding; default build stalls.
module operand_fetch #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs1,
  input  logic [ADDR_WIDTH-1:0] req_rs2,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  rf_write_en,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [ADDR_WIDTH-1:0] rf_read_addr_a,
  input  logic [DATA_WIDTH-1:0] rf_read_data_a,
  output logic [ADDR_WIDTH-1:0] rf_read_addr_b,
  input  logic [DATA_WIDTH-1:0] rf_read_data_b,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_VALID
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] rs1_q;
  logic [ADDR_WIDTH-1:0] rs2_q;
  logic [DATA_WIDTH-1:0] op_a_q;
  logic [DATA_WIDTH-1:0] op_b_q;
  logic                  op_valid_q;

  logic                  idle;
  logic                  accept;
  logic                  zero_a;
  logic                  zero_b;
  logic                  hit_a;
  logic                  hit_b;
  logic                  wait_done;
  logic                  upd_a;
  logic                  upd_b;
  logic [DATA_WIDTH-1:0] op_a_d;
  logic [DATA_WIDTH-1:0] op_b_d;

  assign rf_write_en   = wb_en;
  assign rf_write_addr = wb_addr;
  assign rf_write_data = wb_data;

  assign idle      = (state_q == S_IDLE);
  assign req_ready = idle;
  assign accept    = req_valid & idle;

  assign rf_read_addr_a = idle ? req_rs1 : rs1_q;
  assign rf_read_addr_b = idle ? req_rs2 : rs2_q;

  assign zero_a = (rf_read_addr_a == '0);
  assign zero_b = (rf_read_addr_b == '0);

  // r0 is hard zero, so a write to it never counts as a hit
  assign hit_a = wb_en && (wb_addr != '0)
              && (wb_addr == rf_read_addr_a);
  assign hit_b = wb_en && (wb_addr != '0)
              && (wb_addr == rf_read_addr_b);

`ifdef OPERAND_FETCH_BYPASS_EN
  logic                  fwd_a_q;
  logic                  fwd_b_q;
  logic [DATA_WIDTH-1:0] fwd_a_data_q;
  logic [DATA_WIDTH-1:0] fwd_b_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_a_q      <= 1'b0;
      fwd_b_q      <= 1'b0;
      fwd_a_data_q <= '0;
      fwd_b_data_q <= '0;
    end else if (accept) begin
      fwd_a_q      <= hit_a;
      fwd_b_q      <= hit_b;
      fwd_a_data_q <= wb_data;
      fwd_b_data_q <= wb_data;
    end
  end

  // Youngest source wins: WAIT-cycle write, then accept-cycle write
  always_comb begin
    op_a_d = rf_read_data_a;
    op_b_d = rf_read_data_b;
    if (fwd_a_q) op_a_d = fwd_a_data_q;
    if (fwd_b_q) op_b_d = fwd_b_data_q;
    if (hit_a)   op_a_d = wb_data;
    if (hit_b)   op_b_d = wb_data;
    if (zero_a)  op_a_d = '0;
    if (zero_b)  op_b_d = '0;
  end

  assign wait_done = 1'b1;
  assign upd_a     = hit_a;
  assign upd_b     = hit_b;
`else
  logic haz_q;

  // Set when the previous cycle wrote a source; read data is stale
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      haz_q <= 1'b0;
    end else if (accept || (state_q == S_WAIT)) begin
      haz_q <= hit_a | hit_b;
    end
  end

  always_comb begin
    op_a_d = zero_a ? '0 : rf_read_data_a;
    op_b_d = zero_b ? '0 : rf_read_data_b;
  end

  assign wait_done = !haz_q;
  assign upd_a     = 1'b0;
  assign upd_b     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            rs1_q   <= req_rs1;
            rs2_q   <= req_rs2;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_done) begin
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= 1'b1;
            state_q    <= S_VALID;
          end
        end
        S_VALID: begin
          if (upd_a) op_a_q <= wb_data;
          if (upd_b) op_b_q <= wb_data;
          if (op_ready) begin
            op_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          op_valid_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;

endmodule
